br_stats_mmio: RTL and testbench

BR_STATS_MMIO -- requirements
Module: br_stats_mmio

---
 rtl/br_stats_mmio_pkg.sv | 30 +++
 rtl/br_stats_mmio_sat_cnt32.sv | 34 +++
 rtl/br_stats_mmio.sv | 123 ++++++++++++
 tb/tb_br_stats_mmio.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/br_stats_mmio_pkg.sv
// Shared definitions for the branch-statistics MMIO block: register map,
// control/status bit positions and counter geometry.
package br_stats_mmio_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned N_CNT = 4;

  typedef enum logic [3:0] {
    REG_CTRL     = 4'd0,
    REG_STATUS   = 4'd1,
    REG_BR_LO    = 4'd2,
    REG_BR_HI    = 4'd3,
    REG_HIT_LO   = 4'd4,
    REG_HIT_HI   = 4'd5,
    REG_MISPR_LO = 4'd6,
    REG_MISPR_HI = 4'd7,
    REG_CYC_LO   = 4'd8,
    REG_CYC_HI   = 4'd9
  } reg_off_e;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  // Counter index doubles as its STATUS bit position.
  localparam int unsigned CNT_BR    = 0;
  localparam int unsigned CNT_HIT   = 1;
  localparam int unsigned CNT_MISPR = 2;
  localparam int unsigned CNT_CYC   = 3;

endpackage

// File: rtl/br_stats_mmio_sat_cnt32.sv
// 32-bit saturating event counter with synchronous clear and a one-cycle
// pulse on any increment that lands on (or is held at) the maximum value.
module sat_cnt32
  import br_stats_mmio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_step;
  logic             w_max;

  assign w_step = i_en & i_inc & ~i_clr;
  assign w_max  = &r_cnt;
  assign o_sat  = w_step & (&r_cnt[CNT_W-1:1]);
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_step && !w_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/br_stats_mmio.sv
// Memory-mapped branch predictor statistics: four saturating counters with
// sticky saturation flags and LO-read-latches-HI shadows for tear-free reads.
module br_stats_mmio
  import br_stats_mmio_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hE000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  output logic [15:0] rdata
);

  logic                   w_sel;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_clr;
  logic [N_CNT-1:0]       w_w1c;
  logic [N_CNT-1:0]       w_sat;
  logic [N_CNT-1:0]       w_inc;
  logic [CNT_W-1:0]       w_cnt [N_CNT];
  logic [15:0]            w_rdata;
  logic                   w_unused;

  logic                   r_en;
  logic [N_CNT-1:0]       r_status;
  logic [15:0]            r_shadow [N_CNT];

  assign w_sel = (addr[15:4] == BASE[15:4]);
  assign w_wr  = mm_we & w_sel;
  assign w_rd  = mm_re & w_sel;
  assign w_clr = w_wr && (addr[3:0] == REG_CTRL) && wdata[CTRL_CLR_BIT];
  assign w_w1c = (w_wr && (addr[3:0] == REG_STATUS)) ? wdata[N_CNT-1:0] : '0;
  assign w_unused = ^wdata[15:N_CNT];

  assign w_inc[CNT_BR]    = inc_br_cnt;
  assign w_inc[CNT_HIT]   = inc_hit_cnt;
  assign w_inc[CNT_MISPR] = inc_mispr_cnt;
  assign w_inc[CNT_CYC]   = 1'b1;

  sat_cnt32 u_br (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(r_en), .i_inc(w_inc[CNT_BR]),
    .o_cnt(w_cnt[CNT_BR]), .o_sat(w_sat[CNT_BR])
  );

  sat_cnt32 u_hit (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(r_en), .i_inc(w_inc[CNT_HIT]),
    .o_cnt(w_cnt[CNT_HIT]), .o_sat(w_sat[CNT_HIT])
  );

  sat_cnt32 u_mispr (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(r_en), .i_inc(w_inc[CNT_MISPR]),
    .o_cnt(w_cnt[CNT_MISPR]), .o_sat(w_sat[CNT_MISPR])
  );

  sat_cnt32 u_cyc (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(r_en), .i_inc(w_inc[CNT_CYC]),
    .o_cnt(w_cnt[CNT_CYC]), .o_sat(w_sat[CNT_CYC])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= 1'b0;
    end else if (w_wr && (addr[3:0] == REG_CTRL)) begin
      r_en <= wdata[CTRL_EN_BIT];
    end
  end

  // A saturation event in the same cycle as a W1C keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else if (w_clr) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_w1c) | w_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CNT; i++) r_shadow[i] <= '0;
    end else if (w_clr) begin
      for (int unsigned i = 0; i < N_CNT; i++) r_shadow[i] <= '0;
    end else if (w_rd) begin
      case (addr[3:0])
        REG_BR_LO:    r_shadow[CNT_BR]    <= w_cnt[CNT_BR][31:16];
        REG_HIT_LO:   r_shadow[CNT_HIT]   <= w_cnt[CNT_HIT][31:16];
        REG_MISPR_LO: r_shadow[CNT_MISPR] <= w_cnt[CNT_MISPR][31:16];
        REG_CYC_LO:   r_shadow[CNT_CYC]   <= w_cnt[CNT_CYC][31:16];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (addr[3:0])
        REG_CTRL:     w_rdata = {15'b0, r_en};
        REG_STATUS:   w_rdata = {{(16-N_CNT){1'b0}}, r_status};
        REG_BR_LO:    w_rdata = w_cnt[CNT_BR][15:0];
        REG_BR_HI:    w_rdata = r_shadow[CNT_BR];
        REG_HIT_LO:   w_rdata = w_cnt[CNT_HIT][15:0];
        REG_HIT_HI:   w_rdata = r_shadow[CNT_HIT];
        REG_MISPR_LO: w_rdata = w_cnt[CNT_MISPR][15:0];
        REG_MISPR_HI: w_rdata = r_shadow[CNT_MISPR];
        REG_CYC_LO:   w_rdata = w_cnt[CNT_CYC][15:0];
        REG_CYC_HI:   w_rdata = r_shadow[CNT_CYC];
        default:      w_rdata = '0;
      endcase
    end
  end

  assign rdata = w_rdata;

endmodule

// File: tb/tb_br_stats_mmio.sv
// Directed bench for br_stats_mmio: table-driven register reads after a
// counting burst, plus hand-written carry, saturation, clear and reset cases.
module tb_br_stats_mmio;

  localparam logic [15:0] BASE = 16'hE000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mm_we;
  logic        mm_re;
  logic        inc_br_cnt;
  logic        inc_hit_cnt;
  logic        inc_mispr_cnt;
  logic [15:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;

  br_stats_mmio #(.BASE(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mm_we(mm_we),
    .mm_re(mm_re), .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt),
    .inc_mispr_cnt(inc_mispr_cnt), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  off;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobed read: rdata is sampled before the edge that commits side effects.
  task automatic rd(input logic [3:0] off, output logic [15:0] d);
    addr  = BASE | {12'b0, off};
    mm_re = 1'b1;
    #1;
    d = rdata;
    tick();
    mm_re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [15:0] d);
    addr  = BASE | {12'b0, off};
    wdata = d;
    mm_we = 1'b1;
    tick();
    mm_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [15:0] exp);
    logic [15:0] d;
    rd(off, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [15:0] d;

    rst = 1'b1; addr = BASE; wdata = '0; mm_we = 1'b0; mm_re = 1'b0;
    inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;

    // Reset: strobes and increments held active must have no effect.
    inc_br_cnt = 1'b1; mm_we = 1'b1; wdata = 16'h0001;
    repeat (3) tick();
    chk("rst_ctrl", rdata, 16'h0000);
    inc_br_cnt = 1'b0; mm_we = 1'b0;
    #2 rst = 1'b0;
    tick();
    rd_chk("rst_br_lo", 4'd2, 16'h0000);
    rd_chk("rst_cyc_lo", 4'd8, 16'h0000);
    rd_chk("rst_status", 4'd1, 16'h0000);

    // Counting burst: BR 5, HIT 3, MISPR 2.
    wr(4'd0, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      inc_br_cnt    = 1'b1;
      inc_hit_cnt   = (i < 3);
      inc_mispr_cnt = (i < 2);
      tick();
    end
    inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;

    vecs[0]  = '{"ctrl",     4'd0,  16'h0001};
    vecs[1]  = '{"status",   4'd1,  16'h0000};
    vecs[2]  = '{"br_lo",    4'd2,  16'h0005};
    vecs[3]  = '{"br_hi",    4'd3,  16'h0000};
    vecs[4]  = '{"hit_lo",   4'd4,  16'h0003};
    vecs[5]  = '{"hit_hi",   4'd5,  16'h0000};
    vecs[6]  = '{"mispr_lo", 4'd6,  16'h0002};
    vecs[7]  = '{"mispr_hi", 4'd7,  16'h0000};
    vecs[8]  = '{"cyc_hi",   4'd9,  16'h0000};
    vecs[9]  = '{"reg10",    4'd10, 16'h0000};
    vecs[10] = '{"reg15",    4'd15, 16'h0000};
    vecs[11] = '{"br_lo_again", 4'd2, 16'h0005};
    for (int i = 0; i < 12; i++) begin
      rd_chk(vecs[i].name, vecs[i].off, vecs[i].exp);
    end

    // Carry into the high half and tear-free shadow across an increment.
    dut.u_br.r_cnt = 32'h0000_FFFF;
    inc_br_cnt = 1'b1; tick(); inc_br_cnt = 1'b0;
    rd_chk("carry_lo", 4'd2, 16'h0000);
    inc_br_cnt = 1'b1; tick(); inc_br_cnt = 1'b0;
    rd_chk("carry_hi_shadow", 4'd3, 16'h0001);
    rd_chk("carry_lo_live", 4'd2, 16'h0001);

    // Saturation and sticky STATUS with write-1-to-clear.
    dut.u_br.r_cnt = 32'hFFFF_FFFE;
    inc_br_cnt = 1'b1; repeat (3) tick(); inc_br_cnt = 1'b0;
    rd_chk("sat_lo", 4'd2, 16'hFFFF);
    rd_chk("sat_hi", 4'd3, 16'hFFFF);
    rd_chk("sat_status", 4'd1, 16'h0001);
    wr(4'd1, 16'h0001);
    rd_chk("w1c_status", 4'd1, 16'h0000);
    rd_chk("sat_lo_hold", 4'd2, 16'hFFFF);

    // HIT saturation then CLR racing a BR increment.
    dut.u_hit.r_cnt = 32'hFFFF_FFFF;
    inc_hit_cnt = 1'b1; tick(); inc_hit_cnt = 1'b0;
    rd_chk("hit_sat_status", 4'd1, 16'h0002);
    inc_br_cnt = 1'b1;
    wr(4'd0, 16'h0003);
    inc_br_cnt = 1'b0;
    rd_chk("clr_br_lo", 4'd2, 16'h0000);
    rd_chk("clr_hit_lo", 4'd4, 16'h0000);
    rd_chk("clr_br_hi", 4'd3, 16'h0000);
    rd_chk("clr_status", 4'd1, 16'h0000);
    rd_chk("clr_ctrl_en", 4'd0, 16'h0001);
    inc_br_cnt = 1'b1; tick(); inc_br_cnt = 1'b0;
    rd_chk("post_clr_br", 4'd2, 16'h0001);

    // Disabled counters ignore events; out-of-window accesses are inert.
    wr(4'd0, 16'h0002);
    inc_br_cnt = 1'b1; inc_hit_cnt = 1'b1; inc_mispr_cnt = 1'b1;
    repeat (10) tick();
    inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;
    rd_chk("dis_br_lo", 4'd2, 16'h0000);
    rd_chk("dis_hit_lo", 4'd4, 16'h0000);
    rd_chk("dis_mispr_lo", 4'd6, 16'h0000);
    rd_chk("dis_cyc_lo", 4'd8, 16'h0000);
    addr = BASE + 16'h0010; wdata = 16'h0003; mm_we = 1'b1; mm_re = 1'b1;
    #1 chk("oow_rdata", rdata, 16'h0000);
    tick();
    mm_we = 1'b0; mm_re = 1'b0;
    rd_chk("oow_ctrl", 4'd0, 16'h0000);

    // Simultaneous read and write: read sees the pre-write value.
    addr = BASE; wdata = 16'h0001; mm_we = 1'b1; mm_re = 1'b1;
    #1 chk("rw_ctrl_old", rdata, 16'h0000);
    tick();
    mm_we = 1'b0; mm_re = 1'b0;
    rd_chk("rw_ctrl_new", 4'd0, 16'h0001);
    addr = BASE | 16'h0002; wdata = 16'hFFFF; mm_we = 1'b1; mm_re = 1'b1;
    #1 chk("rw_br_old", rdata, 16'h0000);
    tick();
    mm_we = 1'b0; mm_re = 1'b0;
    rd_chk("rw_br_ignored", 4'd2, 16'h0000);

    // Asynchronous reset in the middle of counting.
    inc_br_cnt = 1'b1;
    addr = BASE | 16'h0002;
    repeat (3) tick();
    chk("pre_rst_br", rdata, 16'h0003);
    #3 rst = 1'b1;
    #1 chk("async_rst_br", rdata, 16'h0000);
    addr = BASE; #1 chk("async_rst_ctrl", rdata, 16'h0000);
    addr = BASE | 16'h0001; #1 chk("async_rst_status", rdata, 16'h0000);
    tick();
    #2 rst = 1'b0;
    repeat (2) tick();
    inc_br_cnt = 1'b0;
    rd_chk("post_rst_br", 4'd2, 16'h0000);

    d = 16'h0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
